// File: rtl/single_port_ram.sv
// Synchronous single-port RAM on a shared tri-state data bus: the master drives
// the bus to write and releases it to read. Define SINGLE_PORT_RAM_RESET_CLEAR_EN
// to have reset also clear every memory word.
module single_port_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  re
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_cmd_c;
  logic                  rd_cmd_c;

  // we=1/re=1 decodes to neither command, so a conflict behaves as idle
  assign wr_cmd_c = we & ~re;
  assign rd_cmd_c = re & ~we;

  // Storage and read register share one block so reset gates writes without a
  // separate synchronous use of rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
`ifdef SINGLE_PORT_RAM_RESET_CLEAR_EN
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
`endif
    end else begin
      if (wr_cmd_c) begin
        mem[addr] <= data;
      end
      if (rd_cmd_c) begin
        rdata <= mem[addr];
      end
    end
  end

  // Output enable follows re/we combinationally; no turnaround cycle
  assign data = rd_cmd_c ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_single_port_ram.sv
// Randomized self-checking bench for single_port_ram against an array-based
// model of the RAM's read/write/conflict rules.
module tb_single_port_ram;

  logic       clk;
  logic       rst_n;
  logic [3:0] addr;
  logic       we;
  logic       re;
  logic [7:0] drv;
  logic       drv_en;
  wire  [7:0] data;

  int checks;
  int errors;

  logic [7:0] mem_m [16];
  logic [7:0] rdata_m;

  assign data = drv_en ? drv : 8'hzz;

  single_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .addr (addr),
    .we   (we),
    .re   (re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: master drives the bus whenever the command is not a READ,
  // so any RAM-side drive outside READ shows up as a corrupted bus value.
  task automatic op(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
    logic is_rd;
    logic is_wr;
    is_rd = r && !w;
    is_wr = w && !r;
    @(negedge clk);
    we     = w;
    re     = r;
    addr   = a;
    drv    = d;
    drv_en = !is_rd;
    #1;
    if (is_rd) check("stale", data, rdata_m);
    @(posedge clk);
    #1;
    if (is_wr) mem_m[a] = d;
    if (is_rd) rdata_m = mem_m[a];
    if (is_rd) check("read", data, rdata_m);
    else       check("bus_release", data, d);
  endtask

  initial begin
    logic [7:0] sq;
    checks  = 0;
    errors  = 0;
    rdata_m = 8'h00;
    rst_n   = 1'b0;
    we      = 1'b0;
    re      = 1'b1;
    addr    = 4'd0;
    drv     = 8'h00;
    drv_en  = 1'b0;
    #3;
    check("reset_bus", data, 8'h00);
    @(negedge clk);
    re    = 1'b0;
    drv_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with squares, read back from the top
    for (int i = 0; i < 16; i++) begin
      sq = 8'(i * i);
      op(1'b1, 1'b0, 4'(i), sq);
    end
    for (int i = 15; i >= 0; i--) begin
      sq = 8'(i * i);
      op(1'b0, 1'b1, 4'(i), 8'h00);
      check("readback", data, sq);
    end

    // Conflict is a no-op and leaves the bus to the master
    op(1'b1, 1'b0, 4'd3, 8'h5A);
    op(1'b1, 1'b1, 4'd3, 8'hFF);
    op(1'b1, 1'b1, 4'd3, 8'h00);
    op(1'b0, 1'b1, 4'd3, 8'h00);
    check("conflict_keep", data, 8'h5A);

    // Idle bus release with complementary probes while rdata is nonzero
    op(1'b0, 1'b0, 4'd3, 8'h00);
    op(1'b0, 1'b0, 4'd3, 8'hA5);

    // Back-to-back write then read
    op(1'b1, 1'b0, 4'd7, 8'h3C);
    op(1'b0, 1'b1, 4'd7, 8'h00);
    check("raw_b2b", data, 8'h3C);

    // Random mix of all four commands
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: op(1'b1, 1'b0, 4'($urandom), 8'($urandom));
        1: op(1'b0, 1'b1, 4'($urandom), 8'($urandom));
        2: op(1'b0, 1'b0, 4'($urandom), 8'($urandom));
        default: op(1'b1, 1'b1, 4'($urandom), 8'($urandom));
      endcase
    end

    // Reset in the middle of a read, with a write attempted during reset
    op(1'b1, 1'b0, 4'd5, 8'h19);
    op(1'b0, 1'b1, 4'd5, 8'h00);
    check("pre_reset_read", data, 8'h19);
    #2;
    rst_n = 1'b0;
    #1;
    rdata_m = 8'h00;
`ifdef SINGLE_PORT_RAM_RESET_CLEAR_EN
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
`endif
    check("reset_bus_drop", data, 8'h00);
    @(negedge clk);
    we     = 1'b1;
    re     = 1'b0;
    addr   = 4'd5;
    drv    = 8'hEE;
    drv_en = 1'b1;
    @(posedge clk);
    #1;
    check("reset_write_bus", data, 8'hEE);
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    op(1'b0, 1'b1, 4'd5, 8'h00);
`ifdef SINGLE_PORT_RAM_RESET_CLEAR_EN
    check("post_reset_read", data, 8'h00);
`else
    check("post_reset_read", data, 8'h19);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
